// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: ARM-style execute stage with NZCV flags, conditional execution, iterative MUL and registered output
module ex_stage_pipe #(
  parameter int WIDTH = 32,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  input  logic [3:0]       cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wb_en,
  output logic             cond_pass,
  output logic [3:0]       nzcv
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] mcand, mplier, prod, x, y, yy, r;
  logic [WIDTH:0] sum;
  logic [7:0] cond_tab;
  logic [3:0] o, f;
  logic n, z, c, v, pass, free, acc, is_mul, cmp_op, arith, rev, sub, use_c, ci, fl_wr, mul_go, ld_alu, ld_mul, mul_s;
  assign {n, z, c, v} = nzcv;
  assign o = op[3:0];
  assign free = ~out_valid | out_ready;
  assign in_ready = rst_n & ~flush & (state == IDLE) & free;
  assign acc = in_valid & in_ready;
  assign cond_tab = {1'b1, ~z & (n == v), n == v, c & ~z, v, n, c, z};
  assign pass = (cond != 4'hf) & (cond_tab[cond[3:1]] ^ cond[0]);
  assign is_mul = op == 5'b10000;
  assign cmp_op = ~op[4] & (o[3:2] == 2'b10);
  assign arith = o inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11};
  assign rev = (o == 4'd3) | (o == 4'd7);
  assign sub = o inside {4'd2, 4'd3, 4'd6, 4'd7, 4'd10};
  assign use_c = o inside {4'd5, 4'd6, 4'd7};
  assign x = rev ? b : a;
  assign y = rev ? a : b;
  assign yy = sub ? ~y : y;
  assign ci = use_c ? c : sub;
  assign sum = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, ci};
  always_comb begin
    r = arith ? sum[WIDTH-1:0] :
        (o == 4'd0 || o == 4'd8) ? a & b :
        (o == 4'd1 || o == 4'd9) ? a ^ b :
        (o == 4'd12) ? a | b :
        (o == 4'd13) ? b :
        (o == 4'd14) ? a & ~b : ~b;
    f = {r[WIDTH-1], r == '0, arith ? sum[WIDTH] : c,
         arith ? (x[WIDTH-1] == yy[WIDTH-1]) & (r[WIDTH-1] != x[WIDTH-1]) : v};
  end
  assign fl_wr = acc & pass & ~op[4] & (s | cmp_op);
  assign mul_go = acc & pass & is_mul;
  assign ld_alu = acc & ~mul_go;
  assign ld_mul = (state == MUL_DONE) & free;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      prod <= '0;
      mul_s <= 1'b0;
      out_valid <= 1'b0;
      result <= '0;
      wb_en <= 1'b0;
      cond_pass <= 1'b0;
      nzcv <= FLAG_RST;
    end else if (flush) begin
      state <= IDLE;
      cnt <= '0;
      out_valid <= 1'b0;
    end else begin
      if (fl_wr) nzcv <= f;
      if (ld_alu) begin
        out_valid <= 1'b1;
        result <= (pass & ~op[4]) ? r : '0;
        wb_en <= pass & ~op[4] & ~cmp_op;
        cond_pass <= pass;
      end else if (ld_mul) begin
        out_valid <= 1'b1;
        result <= prod;
        wb_en <= 1'b1;
        cond_pass <= 1'b1;
        if (mul_s) nzcv[3:2] <= {prod[WIDTH-1], prod == '0};
      end else if (out_ready) out_valid <= 1'b0;
      if (mul_go) begin
        state <= MUL_RUN;
        cnt <= '0;
        mcand <= a;
        mplier <= b;
        prod <= '0;
        mul_s <= s;
      end else if (state == MUL_RUN) begin
        prod <= mplier[0] ? prod + mcand : prod;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= (cnt == CW'(WIDTH - 1)) ? '0 : cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) state <= MUL_DONE;
      end else if (ld_mul) state <= IDLE;
    end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: random and directed checks of ex_stage_pipe against a transaction-level model
module tb_ex_stage_pipe;
  localparam int W = 32;
  localparam logic [3:0] FR = 4'b0000;
  localparam longint MAXU = (longint'(1) << W) - 1;
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));
  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, s, out_valid, out_ready, wb_en, cond_pass;
  logic [4:0] op;
  logic [W-1:0] a, b, result;
  logic [3:0] cond, nzcv;
  int checks = 0, errors = 0;
  logic [3:0] m_f;
  logic m_ov, m_wb, m_cp, m_ms;
  logic [W-1:0] m_res, m_prod;
  int m_left;
  ex_stage_pipe #(.WIDTH(W), .FLAG_RST(FR)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .s(s), .cond(cond), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .wb_en(wb_en), .cond_pass(cond_pass), .nzcv(nzcv)
  );
  always #5 clk = ~clk;
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] fl);
    case (c)
      4'd0: return fl[2];
      4'd1: return !fl[2];
      4'd2: return fl[1];
      4'd3: return !fl[1];
      4'd4: return fl[3];
      4'd5: return !fl[3];
      4'd6: return fl[0];
      4'd7: return !fl[0];
      4'd8: return fl[1] && !fl[2];
      4'd9: return !fl[1] || fl[2];
      4'd10: return fl[3] == fl[0];
      4'd11: return fl[3] != fl[0];
      4'd12: return !fl[2] && fl[3] == fl[0];
      4'd13: return fl[2] || fl[3] != fl[0];
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  function automatic void alu(input logic [3:0] o, input logic [W-1:0] x0, input logic [W-1:0] y0,
                              input logic [3:0] fl, output logic [W-1:0] r, output logic [3:0] nf);
    longint ux, uy, sx, sy, u, sr, k;
    logic cc, vv;
    cc = fl[1];
    vv = fl[0];
    case (o)
      4'd0, 4'd8: r = x0 & y0;
      4'd1, 4'd9: r = x0 ^ y0;
      4'd12: r = x0 | y0;
      4'd13: r = y0;
      4'd14: r = x0 & ~y0;
      4'd15: r = ~y0;
      default: begin
        ux = (o == 4'd3 || o == 4'd7) ? y0 : x0;
        uy = (o == 4'd3 || o == 4'd7) ? x0 : y0;
        sx = (o == 4'd3 || o == 4'd7) ? $signed(y0) : $signed(x0);
        sy = (o == 4'd3 || o == 4'd7) ? $signed(x0) : $signed(y0);
        if (o == 4'd4 || o == 4'd5 || o == 4'd11) begin
          k = (o == 4'd5) ? longint'(fl[1]) : 0;
          u = ux + uy + k;
          sr = sx + sy + k;
          cc = u > MAXU;
        end else begin
          k = (o == 4'd6 || o == 4'd7) ? longint'(!fl[1]) : 0;
          u = ux - uy - k;
          sr = sx - sy - k;
          cc = ux >= uy + k;
        end
        vv = sr > SMAX || sr < SMIN;
        r = u[W-1:0];
      end
    endcase
    nf = {r[W-1], r == '0, cc, vv};
  endfunction
  function automatic logic exp_rdy();
    return rst_n && !flush && m_left == 0 && (!m_ov || out_ready);
  endfunction
  task automatic model_reset();
    m_f = FR;
    m_ov = 1'b0;
    m_res = '0;
    m_wb = 1'b0;
    m_cp = 1'b0;
    m_left = 0;
  endtask
  task automatic model_edge();
    logic acc, p, mul, rsv, cmpop;
    logic [W-1:0] r;
    logic [3:0] nf;
    acc = in_valid && exp_rdy();
    if (!rst_n) model_reset();
    else if (flush) begin
      m_ov = 1'b0;
      m_left = 0;
    end else if (acc) begin
      p = cond_ok(cond, m_f);
      mul = op == 5'd16;
      rsv = op[4] && !mul;
      cmpop = !op[4] && op[3:2] == 2'b10;
      if (mul && p) begin
        m_left = W + 1;
        m_prod = a * b;
        m_ms = s;
        if (out_ready) m_ov = 1'b0;
      end else begin
        alu(op[3:0], a, b, m_f, r, nf);
        m_ov = 1'b1;
        m_res = (p && !op[4]) ? r : '0;
        m_wb = p && !op[4] && !cmpop;
        m_cp = p;
        if (p && !op[4] && (s || cmpop)) m_f = nf;
      end
    end else if (m_left == 1) begin
      if (!m_ov || out_ready) begin
        m_ov = 1'b1;
        m_res = m_prod;
        m_wb = 1'b1;
        m_cp = 1'b1;
        if (m_ms) m_f[3:2] = {m_prod[W-1], m_prod == '0};
        m_left = 0;
      end
    end else begin
      if (m_left > 1) m_left--;
      if (out_ready) m_ov = 1'b0;
    end
  endtask
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("in_ready", W'(in_ready), W'(exp_rdy()));
    chk("out_valid", W'(out_valid), W'(m_ov));
    chk("nzcv", W'(nzcv), W'(m_f));
    if (!rst_n) chk("rst_result", result, '0);
    if (m_ov) begin
      chk("result", result, m_res);
      chk("wb_en", W'(wb_en), W'(m_wb));
      chk("cond_pass", W'(cond_pass), W'(m_cp));
    end
  endtask
  task automatic tick();
    if (!rst_n) model_reset();
    #1;
    check_all();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drv(input logic v, input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic ss, input logic [3:0] c);
    in_valid = v;
    op = o;
    a = x;
    b = y;
    s = ss;
    cond = c;
  endtask
  task automatic idle();
    drv(1'b0, 5'd0, '0, '0, 1'b0, 4'he);
  endtask
  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction
  initial begin
    int low, n;
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    tick();
    tick();
    chk("lit_rst_nzcv", W'(nzcv), W'(FR));
    chk("lit_rst_result", result, '0);
    rst_n = 1'b1;
    tick();
    drv(1'b1, 5'd4, 32'h7fffffff, 32'h1, 1'b1, 4'he);
    tick();
    idle();
    chk("lit_add_result", result, 32'h80000000);
    chk("lit_add_nzcv", W'(nzcv), W'(4'b1001));
    chk("lit_add_wb", W'(wb_en), W'(1'b1));
    drv(1'b1, 5'd2, 32'd5, 32'd5, 1'b1, 4'he);
    tick();
    chk("lit_sub_nzcv", W'(nzcv), W'(4'b0110));
    drv(1'b1, 5'd13, 32'd0, 32'haa, 1'b0, 4'h0);
    tick();
    idle();
    chk("lit_mov_eq_result", result, 32'haa);
    chk("lit_mov_eq_wb", W'(wb_en), W'(1'b1));
    drv(1'b1, 5'd13, 32'd0, 32'h55, 1'b0, 4'h1);
    tick();
    idle();
    chk("lit_ne_wb", W'(wb_en), W'(1'b0));
    chk("lit_ne_cp", W'(cond_pass), W'(1'b0));
    chk("lit_ne_nzcv", W'(nzcv), W'(4'b0110));
    drv(1'b1, 5'd16, 32'h1234, 32'h10, 1'b1, 4'he);
    tick();
    idle();
    low = 0;
    n = 0;
    while (!out_valid && n < 40) begin
      if (!in_ready) low++;
      n++;
      tick();
    end
    chk("lit_mul_busy", W'(low), W'(33));
    chk("lit_mul_result", result, 32'h00012340);
    chk("lit_mul_nzcv", W'(nzcv), W'(4'b0010));
    tick();
    out_ready = 1'b0;
    drv(1'b1, 5'd4, 32'd1, 32'd2, 1'b0, 4'he);
    tick();
    drv(1'b1, 5'd10, 32'd3, 32'd3, 1'b0, 4'he);
    tick();
    tick();
    chk("lit_stall_result", result, 32'd3);
    chk("lit_stall_rdy", W'(in_ready), W'(1'b0));
    out_ready = 1'b1;
    #1;
    chk("lit_release_rdy", W'(in_ready), W'(1'b1));
    tick();
    idle();
    chk("lit_cmp_wb", W'(wb_en), W'(1'b0));
    chk("lit_cmp_nzcv", W'(nzcv), W'(4'b0110));
    drv(1'b1, 5'd16, 32'd7, 32'd9, 1'b1, 4'he);
    tick();
    idle();
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("lit_amid_ov", W'(out_valid), W'(1'b0));
    chk("lit_amid_nzcv", W'(nzcv), W'(FR));
    tick();
    rst_n = 1'b1;
    tick();
    drv(1'b1, 5'd16, 32'd7, 32'd9, 1'b1, 4'he);
    tick();
    idle();
    repeat (5) tick();
    flush = 1'b1;
    drv(1'b1, 5'd4, 32'd1, 32'd1, 1'b1, 4'he);
    tick();
    flush = 1'b0;
    idle();
    repeat (40) tick();
    chk("lit_flush_ov", W'(out_valid), W'(1'b0));
    repeat (4000) begin
      n = $urandom_range(0, 19);
      drv($urandom_range(0, 9) < 7,
          n < 16 ? 5'(n) : n < 18 ? 5'd16 : 5'($urandom_range(17, 31)),
          rnd_opnd(), rnd_opnd(), 1'($urandom), 4'($urandom));
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 99) < 3;
      if ($urandom_range(0, 999) < 2) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end
    rst_n = 1'b1;
    flush = 1'b0;
    idle();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
